// File: rtl/crc_frame_sequencer.sv
// crc_frame_sequencer: drives a byte-serial Modbus CRC-16 engine across a buffered frame
module crc_frame_sequencer #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic [15:0]       crc_out,
   output logic              crc_ok,
   output logic              err,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              eng_reset,
   output logic              eng_start,
   output logic [7:0]        eng_byte,
   input  logic              eng_busy,
   input  logic [15:0]       eng_crc
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   typedef enum logic [2:0] {IDLE, ENG_RST, RD_ADDR, RD_WAIT, STROBE, WAIT_HI, WAIT_LO, FINISH} state_t;
   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [15:0]       crc_out_q, crc_out_d;
   logic              crc_ok_q, crc_ok_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              eng_reset_q, eng_reset_d;
   logic              eng_start_q, eng_start_d;
   logic [7:0]        eng_byte_q, eng_byte_d;
   logic [ADDR_W:0]   idx_nxt;
   logic              len_bad;
   logic              tmo_hit;
   assign idx_nxt = idx_q + {{ADDR_W{1'b0}}, 1'b1};
   assign len_bad = (len == '0) || (mode && (len < (ADDR_W + 1)'(3)));
   assign tmo_hit = (tmo_q == TMO_LAST);
   // next-state and registered-output computation for the frame sequencer
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      len_d       = len_q;
      idx_d       = idx_q;
      tmo_d       = tmo_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      crc_out_d   = crc_out_q;
      crc_ok_d    = crc_ok_q;
      err_d       = err_q;
      rd_addr_d   = rd_addr_q;
      eng_reset_d = 1'b0;
      eng_start_d = 1'b0;
      eng_byte_d  = eng_byte_q;
      case (state_q)
         IDLE: if (start) begin
            mode_d   = mode;
            len_d    = len;
            busy_d   = 1'b1;
            crc_ok_d = 1'b0;
            err_d    = len_bad;
            state_d  = len_bad ? FINISH : ENG_RST;
         end
         ENG_RST: begin
            eng_reset_d = 1'b1;
            idx_d       = '0;
            state_d     = RD_ADDR;
         end
         RD_ADDR: begin
            rd_addr_d = idx_q[ADDR_W-1:0];
            state_d   = RD_WAIT;
         end
         RD_WAIT: state_d = STROBE;
         STROBE: begin
            eng_byte_d  = rd_data;
            eng_start_d = 1'b1;
            tmo_d       = '0;
            state_d     = WAIT_HI;
         end
         WAIT_HI: begin
            if (eng_busy) begin
               tmo_d   = '0;
               state_d = WAIT_LO;
            end else if (tmo_hit) begin
               err_d       = 1'b1;
               eng_reset_d = 1'b1;
               state_d     = FINISH;
            end else
               tmo_d = tmo_q + TW'(1);
         end
         WAIT_LO: begin
            if (!eng_busy) begin
               tmo_d   = '0;
               idx_d   = (idx_nxt == len_q) ? idx_q : idx_nxt;
               state_d = (idx_nxt == len_q) ? FINISH : RD_ADDR;
            end else if (tmo_hit) begin
               err_d       = 1'b1;
               eng_reset_d = 1'b1;
               state_d     = FINISH;
            end else
               tmo_d = tmo_q + TW'(1);
         end
         FINISH: begin
            crc_out_d = err_q ? crc_out_q : eng_crc;
            crc_ok_d  = mode_q && !err_q && (eng_crc == 16'h0000);
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         len_q       <= '0;
         idx_q       <= '0;
         tmo_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         crc_out_q   <= 16'hFFFF;
         crc_ok_q    <= 1'b0;
         err_q       <= 1'b0;
         rd_addr_q   <= '0;
         eng_reset_q <= 1'b1;
         eng_start_q <= 1'b0;
         eng_byte_q  <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         tmo_q       <= tmo_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         crc_out_q   <= crc_out_d;
         crc_ok_q    <= crc_ok_d;
         err_q       <= err_d;
         rd_addr_q   <= rd_addr_d;
         eng_reset_q <= eng_reset_d;
         eng_start_q <= eng_start_d;
         eng_byte_q  <= eng_byte_d;
      end
   end
   assign busy      = busy_q;
   assign done      = done_q;
   assign crc_out   = crc_out_q;
   assign crc_ok    = crc_ok_q;
   assign err       = err_q;
   assign rd_addr   = rd_addr_q;
   assign eng_reset = eng_reset_q;
   assign eng_start = eng_start_q;
   assign eng_byte  = eng_byte_q;
endmodule

// File: tb/tb_crc_frame_sequencer.sv
// tb_crc_frame_sequencer: directed vectors for the CRC frame sequencer with a behavioural engine and RAM
module tb_crc_frame_sequencer;
   localparam int ADDR_W = 8;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic mode = 1'b0;
   logic [ADDR_W:0] len = '0;
   logic busy, done, crc_ok, err, eng_reset, eng_start;
   logic [15:0] crc_out;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0] rd_data = 8'h00;
   logic [7:0] eng_byte;
   logic [15:0] e_crc = 16'hFFFF;
   logic e_busy = 1'b0;
   logic e_prev = 1'b0;
   int e_cnt = 0;
   bit dead = 1'b0;
   logic [7:0] mem [256];
   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;
   int rst_cnt = 0;
   int hi_len = 0;
   int low_len = -1;

   crc_frame_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .len(len),
      .busy(busy), .done(done), .crc_out(crc_out), .crc_ok(crc_ok), .err(err),
      .rd_addr(rd_addr), .rd_data(rd_data), .eng_reset(eng_reset), .eng_start(eng_start),
      .eng_byte(eng_byte), .eng_busy(e_busy), .eng_crc(e_crc)
   );

   always #5 clk = ~clk;

   // synchronous buffer: data appears one cycle after the address is registered
   always @(posedge clk) rd_data <= mem[rd_addr];

   // engine model: strobe edge starts an 11-cycle window (strobe cycle plus 10 busy cycles), 8 shift steps
   always @(posedge clk) begin
      e_prev <= eng_start;
      if (eng_reset) begin
         e_crc  <= 16'hFFFF;
         e_busy <= 1'b0;
         e_cnt  <= 0;
      end else if (eng_start && !e_prev && !e_busy && !dead) begin
         e_crc  <= e_crc ^ {8'h00, eng_byte};
         e_busy <= 1'b1;
         e_cnt  <= 0;
      end else if (e_busy) begin
         if (e_cnt < 8) e_crc <= e_crc[0] ? ((e_crc >> 1) ^ 16'hA001) : (e_crc >> 1);
         if (e_cnt == 9) e_busy <= 1'b0;
         e_cnt <= e_cnt + 1;
      end
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // strobe-shape monitor: every pulse one cycle wide, at least 10 low cycles between pulses
   always @(negedge clk) begin
      if (!reset_n) begin
         hi_len = 0;
         low_len = -1;
      end else begin
         if (eng_reset) rst_cnt++;
         if (eng_start) begin
            if (hi_len == 0) begin
               pulse_cnt++;
               if (low_len >= 0) chk("strobe_gap_ge10", 32'(low_len >= 10), 1);
            end
            hi_len++;
         end else begin
            if (hi_len > 0) begin
               chk("strobe_width", 32'(hi_len), 1);
               low_len = 0;
            end
            if (low_len >= 0) low_len++;
            hi_len = 0;
         end
      end
   end

   task automatic run_frame(input bit m, input int l, input bit hold, output int cyc, output logic b1);
      int n;
      mode = m;
      len = l[ADDR_W:0];
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      b1 = busy;
      n = 1;
      while (!done && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      cyc = done ? n : -1;
   endtask

   task automatic chk_reset(string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_crc_ok"}, 32'(crc_ok), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_eng_start"}, 32'(eng_start), 0);
      chk({tag, "_eng_reset"}, 32'(eng_reset), 1);
      chk({tag, "_crc_out"}, 32'(crc_out), 32'hFFFF);
      chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
      chk({tag, "_eng_byte"}, 32'(eng_byte), 0);
   endtask

   typedef struct {
      bit m;
      int l;
      logic [63:0] data;
      bit chk_crc;
      logic [15:0] crc;
      bit ok;
      bit er;
      int cyc;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int cyc, n, pb, rb;
      logic b1;
      logic [15:0] prev;
      vec_t v;
      vecs[0] = '{1'b0, 6, 64'h0000_0A00_0000_0301, 1'b1, 16'hCDC5, 1'b0, 1'b0, 93};
      vecs[1] = '{1'b1, 8, 64'hCDC5_0A00_0000_0301, 1'b1, 16'h0000, 1'b1, 1'b0, 123};
      vecs[2] = '{1'b1, 8, 64'hCCC5_0A00_0000_0301, 1'b0, 16'h0000, 1'b0, 1'b0, 123};
      vecs[3] = '{1'b0, 0, 64'h0000_0A00_0000_0301, 1'b0, 16'h0000, 1'b0, 1'b1, 2};
      vecs[4] = '{1'b1, 2, 64'h0000_0A00_0000_0301, 1'b0, 16'h0000, 1'b0, 1'b1, 2};
      vecs[5] = '{1'b0, 1, 64'h0000_0000_0000_0001, 1'b1, 16'h807E, 1'b0, 1'b0, 18};
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("por");
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("por_eng_reset_release", 32'(eng_reset), 0);

      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         for (int b = 0; b < 8; b++) mem[b] = v.data[8*b +: 8];
         prev = crc_out;
         pb = pulse_cnt;
         rb = rst_cnt;
         run_frame(v.m, v.l, 1'b0, cyc, b1);
         chk($sformatf("v%0d_accept_busy", i), 32'(b1), 1);
         chk($sformatf("v%0d_done_cycle", i), 32'(cyc), 32'(v.cyc));
         chk($sformatf("v%0d_err", i), 32'(err), 32'(v.er));
         chk($sformatf("v%0d_crc_ok", i), 32'(crc_ok), 32'(v.ok));
         chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 0);
         chk($sformatf("v%0d_strobes", i), 32'(pulse_cnt - pb), v.er ? 0 : 32'(v.l));
         chk($sformatf("v%0d_eng_resets", i), 32'(rst_cnt - rb), v.er ? 0 : 1);
         if (v.er) chk($sformatf("v%0d_crc_kept", i), 32'(crc_out), 32'(prev));
         else if (v.chk_crc) chk($sformatf("v%0d_crc", i), 32'(crc_out), 32'(v.crc));
         @(posedge clk); #1;
         chk($sformatf("v%0d_done_width", i), 32'(done), 0);
      end

      // engine never raises busy: timeout after 32 cycles in WAIT_HI
      for (int b = 0; b < 8; b++) mem[b] = vecs[0].data[8*b +: 8];
      dead = 1'b1;
      prev = crc_out;
      pb = pulse_cnt;
      rb = rst_cnt;
      run_frame(1'b0, 6, 1'b0, cyc, b1);
      chk("tmo_done_cycle", 32'(cyc), 38);
      chk("tmo_err", 32'(err), 1);
      chk("tmo_crc_kept", 32'(crc_out), 32'(prev));
      chk("tmo_crc_ok", 32'(crc_ok), 0);
      chk("tmo_strobes", 32'(pulse_cnt - pb), 1);
      chk("tmo_eng_resets", 32'(rst_cnt - rb), 2);
      dead = 1'b0;
      @(posedge clk); #1;

      // reset during the third byte of a six-byte frame
      mode = 1'b0;
      len = 9'd6;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (n = 1; n < 38; n++) begin
         @(posedge clk); #1;
      end
      chk("midrst_busy_before", 32'(busy), 1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk_reset("midrst");
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_eng_reset_release", 32'(eng_reset), 0);
      run_frame(1'b0, 6, 1'b0, cyc, b1);
      chk("after_rst_cycle", 32'(cyc), 93);
      chk("after_rst_crc", 32'(crc_out), 32'hCDC5);
      chk("after_rst_err", 32'(err), 0);
      @(posedge clk); #1;

      // back-to-back with start held, then a stray start pulse mid-frame
      run_frame(1'b0, 6, 1'b1, cyc, b1);
      chk("b2b1_cycle", 32'(cyc), 93);
      chk("b2b1_crc", 32'(crc_out), 32'hCDC5);
      @(posedge clk); #1;
      chk("b2b2_accept_busy", 32'(busy), 1);
      start = 1'b0;
      n = 1;
      repeat (20) begin
         @(posedge clk); #1;
         n++;
      end
      mode = 1'b1;
      len = '0;
      start = 1'b1;
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      while (!done && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b2b2_cycle", 32'(done ? n : -1), 93);
      chk("b2b2_crc", 32'(crc_out), 32'hCDC5);
      chk("b2b2_err", 32'(err), 0);
      chk("b2b2_crc_ok", 32'(crc_ok), 0);
      @(posedge clk); #1;
      chk("b2b2_idle_after", 32'(busy), 0);
      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/crc_frame_sequencer.md
Name: crc_frame_sequencer

Overview:
- Sequences the single-byte Modbus CRC-16 engine (poly 0xA001, init 0xFFFF, 11-cycle busy window) over a whole frame held in a synchronous byte buffer.
- Resets the engine, fetches bytes one at a time, strobes each into the engine, and waits on engine busy between bytes.
- Returns the final CRC (GEN mode) or a pass/fail residue check (CHECK mode).
- Sits between the master's frame buffer and the CRC engine; serves both the TX-append path and the RX-validate path.

Parameters:
- ADDR_W, 8: buffer address width; maximum frame length is 2^ADDR_W bytes.
- TIMEOUT, 32: maximum cycles spent waiting on any single engine busy edge before declaring an error.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- start  in  1  frame request; sampled only in IDLE.
- mode  in  1  0 = GEN, 1 = CHECK; captured at accept.
- len  in  ADDR_W+1  byte count; captured at accept.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse when the result is valid.
- crc_out  out  16  engine result; held until the next done.
- crc_ok  out  1  CHECK result; held.
- err  out  1  length or timeout error; held.
- rd_addr  out  ADDR_W  buffer read address.
- rd_data  in  8  buffer data; valid 1 cycle after rd_addr is registered.
- eng_reset  out  1  engine reset (active-high).
- eng_start  out  1  engine strobe.
- eng_byte  out  8  engine data byte.
- eng_busy  in  1  engine busy.
- eng_crc  in  16  engine crc_16 output.

Behaviour:
- All outputs are registered.
- Reset (reset_n=0 at a clk edge), including mid-frame, forces these values:
  - state=IDLE;
  - busy, done, crc_ok, err, eng_start = 0;
  - eng_reset=1;
  - crc_out=16'hFFFF;
  - rd_addr=0, eng_byte=0;
  - the byte index and timeout counter are cleared.
- eng_reset deasserts on the first edge with reset_n=1.
- State machine:
  - IDLE: when start=1, accept: capture mode/len, busy<=1, clear err/crc_ok. If len=0, or mode=1 with len<3, go to FINISH with err=1. Otherwise go to ENG_RST. start is ignored while busy=1.
  - ENG_RST: eng_reset<=1 for exactly one cycle; idx<=0; go to RD_ADDR.
  - RD_ADDR: eng_reset<=0; rd_addr<=idx; go to RD_WAIT.
  - RD_WAIT: one cycle for RAM latency; go to STROBE.
  - STROBE: eng_byte<=rd_data; eng_start<=1; go to WAIT_HI.
  - WAIT_HI: eng_start<=0, so the strobe is exactly one cycle wide and the engine's edge detector re-arms. Wait for eng_busy=1, then go to WAIT_LO.
  - WAIT_LO: wait for eng_busy=0. Then, if idx=len-1, go to FINISH; otherwise idx<=idx+1 and go to RD_ADDR.
  - FINISH: crc_out<=eng_crc (unless err); crc_ok<=(mode=1 && !err && eng_crc==16'h0000); done<=1 for one cycle; busy<=0; go to IDLE.
- eng_byte is held stable from STROBE until the next STROBE.
- Timeout: a counter runs in WAIT_HI and WAIT_LO and clears on each state entry. When it reaches TIMEOUT, set err=1, pulse eng_reset for one cycle, go to FINISH. crc_out keeps its previous value.
- Latency, with the accept cycle counted as 0:
  - each byte takes 15 cycles;
  - done is high in cycle 15*len+3;
  - error on length: done is high in cycle 2.
- Byte order: the engine sees bytes in address order 0..len-1.
- CHECK mode runs over the whole frame including the 2 appended CRC bytes (low byte first); residue 0 means pass.
- len=2^ADDR_W is legal: idx reaches 2^ADDR_W-1 without wrap, and the counter is ADDR_W+1 bits wide.
- start held high continuously: a new frame is accepted on the first IDLE cycle after done.

Test Plan:
- GEN, buffer {01,03,00,00,00,0A}, len=6 -> crc_out=16'hCDC5 (appended C5 CD); done in cycle 93; crc_ok=0, err=0.
- CHECK, buffer {01,03,00,00,00,0A,C5,CD}, len=8 -> crc_ok=1, crc_out=0000, done in cycle 123. Then corrupt the last byte to CC -> crc_ok=0, err=0.
- len=0 (GEN), and CHECK with len=2 -> done in cycle 2, err=1; eng_start never pulses; crc_out unchanged.
- Engine model holds eng_busy=0 forever -> err=1 with done exactly TIMEOUT cycles after WAIT_HI entry (+1 for FINISH); eng_reset pulses once.
- reset_n low for 1 cycle during byte 3 of a 6-byte frame -> all outputs at reset values next cycle. A following full frame {01,03,00,00,00,0A} still gives CDC5, proving the engine was re-initialised.
- Back-to-back frames with start held high, plus start pulsed mid-frame -> the second frame begins in the cycle after done; the mid-frame pulse is ignored; each eng_start pulse is exactly 1 cycle, and low for ≥10 cycles between pulses.
